l1_cache_control: RTL and testbench

- Control FSM for the 2-way set-associative, write-back L1 cache.
- Sequences the per-way valid/dirty/tag meta arrays, the per-set LRU meta array and the data array.
- Sits between the CPU-side memory port (mem_*) and the physical-memory port (pmem_*).
- The datapath does the tag compare and returns per-way hit/dirty status. This block returns all load strobes and mux selects.

---
 rtl/l1_cache_control_if.sv | 49 ++++
 rtl/l1_cache_control.sv | 151 +++++++++++++++
 tb/tb_l1_cache_control.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/l1_cache_control_if.sv
// Purpose: bundles the CPU port, the datapath status/strobes and the
// physical-memory port of the L1 cache controller.
// Modports:
//   slave  - the controller: takes requests and status, drives strobes,
//            mem_resp and the pmem request lines.
//   master - the environment (CPU, datapath, pmem) facing the controller.
// Signals:
//   mem_read/mem_write/mem_resp       CPU request handshake
//   hit/dirty/lru                     per-set status from the datapath
//   valid_load/dirty_load/dirty_in    valid/dirty meta array writes
//   tag_load/lru_load/lru_in          tag and LRU array writes
//   data_load/data_in_sel             data array write enable and source
//   pmem_addr_sel/pmem_read/pmem_write/pmem_resp  physical-memory port
interface l1_cache_control_if;
  localparam int unsigned NUM_WAYS = 2;

  logic                mem_read;
  logic                mem_write;
  logic                mem_resp;
  logic [NUM_WAYS-1:0] hit;
  logic [NUM_WAYS-1:0] dirty;
  logic                lru;
  logic [NUM_WAYS-1:0] valid_load;
  logic [NUM_WAYS-1:0] dirty_load;
  logic                dirty_in;
  logic [NUM_WAYS-1:0] tag_load;
  logic                lru_load;
  logic                lru_in;
  logic [NUM_WAYS-1:0] data_load;
  logic                data_in_sel;
  logic                pmem_addr_sel;
  logic                pmem_read;
  logic                pmem_write;
  logic                pmem_resp;

  modport slave (
    input  mem_read, mem_write, hit, dirty, lru, pmem_resp,
    output mem_resp, valid_load, dirty_load, dirty_in, tag_load,
           lru_load, lru_in, data_load, data_in_sel,
           pmem_addr_sel, pmem_read, pmem_write
  );

  modport master (
    output mem_read, mem_write, hit, dirty, lru, pmem_resp,
    input  mem_resp, valid_load, dirty_load, dirty_in, tag_load,
           lru_load, lru_in, data_load, data_in_sel,
           pmem_addr_sel, pmem_read, pmem_write
  );
endinterface

// File: rtl/l1_cache_control.sv
// Purpose: control FSM of the 2-way set-associative write-back L1 cache.
// Sequences the valid/dirty/tag/LRU meta arrays and the data array, and
// handles line writeback and fill over the physical-memory port.
// Ports:
//   clk        clock, all state changes on posedge
//   rst        synchronous active-high reset
//   bus        l1_cache_control_if.slave (CPU, datapath and pmem signals)
//   hit_count  COMPARE hits that responded (L1_PERF_CNT_EN only, else 0)
//   miss_count COMPARE misses (L1_PERF_CNT_EN only, else 0)
// Configuration: define L1_PERF_CNT_EN to build the saturating hit/miss
// performance counters; without it both counter outputs are tied to 0.
// All bus outputs are decoded combinationally from the state so that a hit
// responds in the cycle the request becomes visible.
module l1_cache_control #(
  parameter int unsigned CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  l1_cache_control_if.slave    bus,
  output logic [CNT_WIDTH-1:0] hit_count,
  output logic [CNT_WIDTH-1:0] miss_count
);

  typedef enum logic [1:0] {
    COMPARE   = 2'd0,
    WRITEBACK = 2'd1,
    ALLOCATE  = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic req;
  logic is_write;
  logic any_hit;
  logic hit_way;

  // A simultaneous read and write is serviced as a write.
  assign req      = bus.mem_read | bus.mem_write;
  assign is_write = bus.mem_write;
  assign any_hit  = |bus.hit;
  // Way 0 takes priority when both ways report a hit.
  assign hit_way  = ~bus.hit[0];

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= COMPARE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and strobe decode
  always_comb begin
    state_d           = state_q;
    bus.mem_resp      = 1'b0;
    bus.valid_load    = 2'b00;
    bus.dirty_load    = 2'b00;
    bus.dirty_in      = 1'b0;
    bus.tag_load      = 2'b00;
    bus.lru_load      = 1'b0;
    bus.lru_in        = 1'b0;
    bus.data_load     = 2'b00;
    bus.data_in_sel   = 1'b0;
    bus.pmem_addr_sel = 1'b0;
    bus.pmem_read     = 1'b0;
    bus.pmem_write    = 1'b0;

    unique case (state_q)
      COMPARE: begin
        if (req && any_hit) begin
          bus.mem_resp = 1'b1;
          bus.lru_load = 1'b1;
          bus.lru_in   = ~hit_way;
          if (is_write) begin
            bus.data_load   = hit_way ? 2'b10 : 2'b01;
            bus.dirty_load  = hit_way ? 2'b10 : 2'b01;
            bus.dirty_in    = 1'b1;
            bus.data_in_sel = 1'b0;
          end
        end else if (req) begin
          // Victim is the LRU way; only a dirty victim needs writing back.
          state_d = bus.dirty[bus.lru] ? WRITEBACK : ALLOCATE;
        end
      end

      WRITEBACK: begin
        bus.pmem_write    = 1'b1;
        bus.pmem_addr_sel = 1'b1;
        if (bus.pmem_resp) begin
          state_d = ALLOCATE;
        end
      end

      ALLOCATE: begin
        bus.pmem_read     = 1'b1;
        bus.pmem_addr_sel = 1'b0;
        // Fill completes regardless of whether the request is still held.
        if (bus.pmem_resp) begin
          bus.data_load   = bus.lru ? 2'b10 : 2'b01;
          bus.data_in_sel = 1'b1;
          bus.tag_load    = bus.lru ? 2'b10 : 2'b01;
          bus.valid_load  = bus.lru ? 2'b10 : 2'b01;
          bus.dirty_load  = bus.lru ? 2'b10 : 2'b01;
          bus.dirty_in    = 1'b0;
          state_d         = COMPARE;
        end
      end

      default: begin
        state_d = COMPARE;
      end
    endcase
  end

`ifdef L1_PERF_CNT_EN
  logic [CNT_WIDTH-1:0] hit_cnt_q, hit_cnt_d;
  logic [CNT_WIDTH-1:0] miss_cnt_q, miss_cnt_d;

  // Saturating counters: a hit is any responding COMPARE hit, a miss is a
  // COMPARE exit towards WRITEBACK or ALLOCATE.
  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if ((state_q == COMPARE) && req && any_hit && !(&hit_cnt_q)) begin
      hit_cnt_d = hit_cnt_q + CNT_WIDTH'(1);
    end
    if ((state_q == COMPARE) && req && !any_hit && !(&miss_cnt_q)) begin
      miss_cnt_d = miss_cnt_q + CNT_WIDTH'(1);
    end
  end

  // Counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;
`else
  assign hit_count  = '0;
  assign miss_count = '0;
`endif

endmodule

// File: tb/tb_l1_cache_control.sv
// Purpose: directed self-checking bench for l1_cache_control. Walks through
// reset, clean and dirty misses, write/read hits, simultaneous read+write,
// stray pmem_resp, an abandoned request and reset during a fill, comparing
// the full strobe vector and the performance counters each step.
module tb_l1_cache_control;
  localparam int unsigned CNT_WIDTH = 32;
`ifdef L1_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic clk;
  logic rst;
  logic [CNT_WIDTH-1:0] hit_count;
  logic [CNT_WIDTH-1:0] miss_count;
  int n_checks;
  int n_errors;

  l1_cache_control_if bus ();

  l1_cache_control #(.CNT_WIDTH(CNT_WIDTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .hit_count  (hit_count),
    .miss_count (miss_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Packed view of every controller output, MSB first.
  logic [15:0] obs;
  assign obs = {bus.mem_resp, bus.valid_load, bus.dirty_load, bus.dirty_in,
                bus.tag_load, bus.lru_load, bus.lru_in, bus.data_load,
                bus.data_in_sel, bus.pmem_addr_sel, bus.pmem_read,
                bus.pmem_write};

  function automatic logic [15:0] mk(
    input logic       resp, input logic [1:0] vl, input logic [1:0] dl,
    input logic       di,   input logic [1:0] tl, input logic ll,
    input logic       li,   input logic [1:0] dat, input logic ds,
    input logic       as,   input logic pr, input logic pw);
    return {resp, vl, dl, di, tl, ll, li, dat, ds, as, pr, pw};
  endfunction

  localparam logic [15:0] IDLE = 16'h0000;
  logic [15:0] alloc_wait, wb_wait, fill0, fill1, resp_r_w0, resp_r_w1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_ctl(input string tag, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_cnt(input string tag, input int unsigned h, input int unsigned m);
    logic [CNT_WIDTH-1:0] eh, em;
    eh = PERF ? CNT_WIDTH'(h) : '0;
    em = PERF ? CNT_WIDTH'(m) : '0;
    n_checks++;
    assert (hit_count === eh) else begin
      n_errors++;
      $error("FAIL %s_hit: observed %0d expected %0d", tag, hit_count, eh);
    end
    n_checks++;
    assert (miss_count === em) else begin
      n_errors++;
      $error("FAIL %s_miss: observed %0d expected %0d", tag, miss_count, em);
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    alloc_wait = mk(0, 2'b00, 2'b00, 0, 2'b00, 0, 0, 2'b00, 0, 0, 1, 0);
    wb_wait    = mk(0, 2'b00, 2'b00, 0, 2'b00, 0, 0, 2'b00, 0, 1, 0, 1);
    fill0      = mk(0, 2'b01, 2'b01, 0, 2'b01, 0, 0, 2'b01, 1, 0, 1, 0);
    fill1      = mk(0, 2'b10, 2'b10, 0, 2'b10, 0, 0, 2'b10, 1, 0, 1, 0);
    resp_r_w0  = mk(1, 2'b00, 2'b00, 0, 2'b00, 1, 1, 2'b00, 0, 0, 0, 0);
    resp_r_w1  = mk(1, 2'b00, 2'b00, 0, 2'b00, 1, 0, 2'b00, 0, 0, 0, 0);

    rst = 1'b1;
    bus.mem_read = 1'b0; bus.mem_write = 1'b0; bus.hit = 2'b00;
    bus.dirty = 2'b00;   bus.lru = 1'b0;       bus.pmem_resp = 1'b0;
    tick(); tick();
    #2 chk_ctl("reset_ctl", IDLE);
    rst = 1'b0;
    chk_cnt("reset_cnt", 0, 0);

    // Clean read miss to an all-invalid set, fill after 5 cycles.
    bus.mem_read = 1'b1;
    #2 chk_ctl("clean_miss_compare", IDLE);
    tick();
    for (int i = 0; i < 5; i++) begin
      #2 chk_ctl("clean_miss_alloc_wait", alloc_wait);
      tick();
    end
    bus.pmem_resp = 1'b1;
    #2 chk_ctl("clean_miss_fill_way0", fill0);
    tick();
    bus.pmem_resp = 1'b0; bus.hit = 2'b01;
    #2 chk_ctl("post_fill_read_hit", resp_r_w0);
    tick();
    chk_cnt("after_clean_miss", 1, 1);
    bus.mem_read = 1'b0; bus.hit = 2'b00;
    #2 chk_ctl("idle_after_clean_miss", IDLE);

    // Write hit in way 1.
    bus.mem_write = 1'b1; bus.hit = 2'b10;
    #2 chk_ctl("write_hit_way1", mk(1, 2'b00, 2'b10, 1, 2'b00, 1, 0, 2'b10, 0, 0, 0, 0));
    tick();
    bus.mem_write = 1'b0; bus.hit = 2'b00;

    // Dirty read miss: writeback then fill into way 1.
    bus.mem_read = 1'b1; bus.lru = 1'b1; bus.dirty = 2'b10;
    #2 chk_ctl("dirty_miss_compare", IDLE);
    tick();
    #2 chk_ctl("writeback_wait0", wb_wait);
    tick();
    #2 chk_ctl("writeback_wait1", wb_wait);
    bus.pmem_resp = 1'b1;
    #2 chk_ctl("writeback_resp", wb_wait);
    tick();
    bus.pmem_resp = 1'b0;
    #2 chk_ctl("dirty_miss_alloc_wait", alloc_wait);
    bus.pmem_resp = 1'b1;
    #2 chk_ctl("dirty_miss_fill_way1", fill1);
    tick();
    bus.pmem_resp = 1'b0; bus.hit = 2'b10;
    #2 chk_ctl("post_fill_read_hit_w1", resp_r_w1);
    tick();
    bus.mem_read = 1'b0; bus.hit = 2'b00; bus.dirty = 2'b00; bus.lru = 1'b0;

    // Read and write together, both ways hit: way 0 write.
    bus.mem_read = 1'b1; bus.mem_write = 1'b1; bus.hit = 2'b11;
    #2 chk_ctl("rw_both_hit_way0", mk(1, 2'b00, 2'b01, 1, 2'b00, 1, 1, 2'b01, 0, 0, 0, 0));
    tick();
    bus.mem_read = 1'b0; bus.mem_write = 1'b0; bus.hit = 2'b00;

    // Stray pmem_resp while idle is ignored.
    bus.pmem_resp = 1'b1;
    #2 chk_ctl("stray_pmem_resp", IDLE);
    tick();
    bus.pmem_resp = 1'b0;
    #2 chk_ctl("stray_pmem_resp_after", IDLE);

    // Read hit in way 1, then counters: 5 hits, 2 misses.
    bus.mem_read = 1'b1; bus.hit = 2'b10;
    #2 chk_ctl("read_hit_way1", resp_r_w1);
    tick();
    bus.mem_read = 1'b0; bus.hit = 2'b00;
    chk_cnt("five_hits_two_misses", 5, 2);

    // Request dropped mid-miss: fill completes, no response.
    bus.mem_read = 1'b1;
    #2 chk_ctl("abandon_compare", IDLE);
    tick();
    bus.mem_read = 1'b0;
    #2 chk_ctl("abandon_alloc_wait", alloc_wait);
    bus.pmem_resp = 1'b1;
    #2 chk_ctl("abandon_fill", fill0);
    tick();
    bus.pmem_resp = 1'b0;
    #2 chk_ctl("abandon_no_resp", IDLE);
    chk_cnt("abandon_cnt", 5, 3);

    // Reset during ALLOCATE drops pmem_read next cycle.
    bus.mem_read = 1'b1;
    #2 chk_ctl("rst_alloc_compare", IDLE);
    tick();
    #2 chk_ctl("rst_alloc_wait", alloc_wait);
    rst = 1'b1;
    #2 chk_ctl("rst_alloc_same_cycle", alloc_wait);
    tick();
    #2 chk_ctl("rst_alloc_dropped", IDLE);
    chk_cnt("rst_alloc_cnt", 0, 0);
    rst = 1'b0; bus.mem_read = 1'b0;
    tick();
    #2 chk_ctl("rst_alloc_idle", IDLE);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
